// File: rtl/register_bank.sv
// 32 x WIDTH register storage feeding a 32:1 read mux, with written-since-clear mask.
// Latency: write visible on RegOutN one edge after it is presented; WriteAck follows the same edge.
// Backpressure: none; every write is accepted except a write to entry 0 when it is hardwired to zero.
module register_bank #(
    parameter int WIDTH     = 32,
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Write,
    input  logic [4:0]       WriteAddr,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             ClearDirty,
    output logic [WIDTH-1:0] RegOut0,
    output logic [WIDTH-1:0] RegOut1,
    output logic [WIDTH-1:0] RegOut2,
    output logic [WIDTH-1:0] RegOut3,
    output logic [WIDTH-1:0] RegOut4,
    output logic [WIDTH-1:0] RegOut5,
    output logic [WIDTH-1:0] RegOut6,
    output logic [WIDTH-1:0] RegOut7,
    output logic [WIDTH-1:0] RegOut8,
    output logic [WIDTH-1:0] RegOut9,
    output logic [WIDTH-1:0] RegOut10,
    output logic [WIDTH-1:0] RegOut11,
    output logic [WIDTH-1:0] RegOut12,
    output logic [WIDTH-1:0] RegOut13,
    output logic [WIDTH-1:0] RegOut14,
    output logic [WIDTH-1:0] RegOut15,
    output logic [WIDTH-1:0] RegOut16,
    output logic [WIDTH-1:0] RegOut17,
    output logic [WIDTH-1:0] RegOut18,
    output logic [WIDTH-1:0] RegOut19,
    output logic [WIDTH-1:0] RegOut20,
    output logic [WIDTH-1:0] RegOut21,
    output logic [WIDTH-1:0] RegOut22,
    output logic [WIDTH-1:0] RegOut23,
    output logic [WIDTH-1:0] RegOut24,
    output logic [WIDTH-1:0] RegOut25,
    output logic [WIDTH-1:0] RegOut26,
    output logic [WIDTH-1:0] RegOut27,
    output logic [WIDTH-1:0] RegOut28,
    output logic [WIDTH-1:0] RegOut29,
    output logic [WIDTH-1:0] RegOut30,
    output logic [WIDTH-1:0] RegOut31,
    output logic [31:0]      Dirty,
    output logic             WriteAck
);

    logic [WIDTH-1:0] regs [32];
    logic [31:0]      write_sel;
    logic             write_accept;

    // One-hot destination decode; entry-0 writes are dropped when entry 0 is hardwired.
    always_comb begin
        write_sel    = 32'd1 << WriteAddr;
        write_accept = Write && !(ZERO_REG0 && (WriteAddr == 5'd0));
    end

    // Register storage: reset clears everything, otherwise only the decoded entry loads.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (write_accept && write_sel[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    // Dirty mask: clear wins over history, but a same-cycle write still marks its own entry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Dirty <= 32'd0;
        end else if (ClearDirty) begin
            Dirty <= write_accept ? write_sel : 32'd0;
        end else if (write_accept) begin
            Dirty <= Dirty | write_sel;
        end
    end

    // Acknowledge pulse for exactly the cycle after each committed write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            WriteAck <= 1'b0;
        end else begin
            WriteAck <= write_accept;
        end
    end

    // Outputs come straight from storage; entry 0 may be forced to constant zero.
    assign RegOut0  = ZERO_REG0 ? '0 : regs[0];
    assign RegOut1  = regs[1];
    assign RegOut2  = regs[2];
    assign RegOut3  = regs[3];
    assign RegOut4  = regs[4];
    assign RegOut5  = regs[5];
    assign RegOut6  = regs[6];
    assign RegOut7  = regs[7];
    assign RegOut8  = regs[8];
    assign RegOut9  = regs[9];
    assign RegOut10 = regs[10];
    assign RegOut11 = regs[11];
    assign RegOut12 = regs[12];
    assign RegOut13 = regs[13];
    assign RegOut14 = regs[14];
    assign RegOut15 = regs[15];
    assign RegOut16 = regs[16];
    assign RegOut17 = regs[17];
    assign RegOut18 = regs[18];
    assign RegOut19 = regs[19];
    assign RegOut20 = regs[20];
    assign RegOut21 = regs[21];
    assign RegOut22 = regs[22];
    assign RegOut23 = regs[23];
    assign RegOut24 = regs[24];
    assign RegOut25 = regs[25];
    assign RegOut26 = regs[26];
    assign RegOut27 = regs[27];
    assign RegOut28 = regs[28];
    assign RegOut29 = regs[29];
    assign RegOut30 = regs[30];
    assign RegOut31 = regs[31];

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: one instance with entry 0 hardwired, one with entry 0 ordinary.
// A behavioural model tracks both; a downstream 32:1 mux is modelled on the first instance.
module tb_register_bank;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Write = 1'b0;
    logic [4:0]  WriteAddr = 5'd0;
    logic [31:0] WriteData = 32'd0;
    logic        ClearDirty = 1'b0;
    logic [4:0]  sel = 5'd0;

    logic [31:0][31:0] oa;
    logic [31:0][31:0] ob;
    logic [31:0]       dirty_a, dirty_b;
    logic              ack_a, ack_b;
    logic [31:0]       mux_out;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign mux_out = oa[sel];

    register_bank #(.WIDTH(32), .ZERO_REG0(1'b1)) dut_a (
        .Clk(Clk), .Reset(Reset), .Write(Write), .WriteAddr(WriteAddr),
        .WriteData(WriteData), .ClearDirty(ClearDirty),
        .RegOut0(oa[0]),   .RegOut1(oa[1]),   .RegOut2(oa[2]),   .RegOut3(oa[3]),
        .RegOut4(oa[4]),   .RegOut5(oa[5]),   .RegOut6(oa[6]),   .RegOut7(oa[7]),
        .RegOut8(oa[8]),   .RegOut9(oa[9]),   .RegOut10(oa[10]), .RegOut11(oa[11]),
        .RegOut12(oa[12]), .RegOut13(oa[13]), .RegOut14(oa[14]), .RegOut15(oa[15]),
        .RegOut16(oa[16]), .RegOut17(oa[17]), .RegOut18(oa[18]), .RegOut19(oa[19]),
        .RegOut20(oa[20]), .RegOut21(oa[21]), .RegOut22(oa[22]), .RegOut23(oa[23]),
        .RegOut24(oa[24]), .RegOut25(oa[25]), .RegOut26(oa[26]), .RegOut27(oa[27]),
        .RegOut28(oa[28]), .RegOut29(oa[29]), .RegOut30(oa[30]), .RegOut31(oa[31]),
        .Dirty(dirty_a), .WriteAck(ack_a)
    );

    register_bank #(.WIDTH(32), .ZERO_REG0(1'b0)) dut_b (
        .Clk(Clk), .Reset(Reset), .Write(Write), .WriteAddr(WriteAddr),
        .WriteData(WriteData), .ClearDirty(ClearDirty),
        .RegOut0(ob[0]),   .RegOut1(ob[1]),   .RegOut2(ob[2]),   .RegOut3(ob[3]),
        .RegOut4(ob[4]),   .RegOut5(ob[5]),   .RegOut6(ob[6]),   .RegOut7(ob[7]),
        .RegOut8(ob[8]),   .RegOut9(ob[9]),   .RegOut10(ob[10]), .RegOut11(ob[11]),
        .RegOut12(ob[12]), .RegOut13(ob[13]), .RegOut14(ob[14]), .RegOut15(ob[15]),
        .RegOut16(ob[16]), .RegOut17(ob[17]), .RegOut18(ob[18]), .RegOut19(ob[19]),
        .RegOut20(ob[20]), .RegOut21(ob[21]), .RegOut22(ob[22]), .RegOut23(ob[23]),
        .RegOut24(ob[24]), .RegOut25(ob[25]), .RegOut26(ob[26]), .RegOut27(ob[27]),
        .RegOut28(ob[28]), .RegOut29(ob[29]), .RegOut30(ob[30]), .RegOut31(ob[31]),
        .Dirty(dirty_b), .WriteAck(ack_b)
    );

    // Behavioural model: index 0 = hardwired-zero instance, index 1 = ordinary instance.
    logic [31:0] m_reg   [2][32];
    logic [31:0] m_dirty [2];
    logic        m_ack   [2];
    logic        m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model update at each rising edge, from the block's rules.
    always @(posedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                for (int i = 0; i < 32; i++) m_reg[k][i] = 32'd0;
                m_dirty[k] = 32'd0;
                m_ack[k]   = 1'b0;
            end else begin
                bit dropped;
                bit taken;
                dropped = (k == 0) && (WriteAddr == 5'd0);
                taken   = Write && !dropped;
                if (ClearDirty) m_dirty[k] = 32'd0;
                if (taken) begin
                    m_reg[k][WriteAddr]   = WriteData;
                    m_dirty[k][WriteAddr] = 1'b1;
                end
                m_ack[k] = taken;
            end
        end
        if (Reset) m_valid = 1'b1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge Clk) begin
        if (m_valid) begin
            for (int i = 0; i < 32; i++) begin
                check($sformatf("a_reg%0d", i), oa[i], m_reg[0][i]);
                check($sformatf("b_reg%0d", i), ob[i], m_reg[1][i]);
            end
            check("a_dirty", dirty_a, m_dirty[0]);
            check("b_dirty", dirty_b, m_dirty[1]);
            check("a_ack", {31'd0, ack_a}, {31'd0, m_ack[0]});
            check("b_ack", {31'd0, ack_b}, {31'd0, m_ack[1]});
        end
    end

    // Apply one cycle of inputs at a falling edge; return at the next falling edge.
    task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic clr, input logic rst);
        Write      = w;
        WriteAddr  = a;
        WriteData  = d;
        ClearDirty = clr;
        Reset      = rst;
        @(negedge Clk);
    endtask

    initial begin
        @(negedge Clk);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        check("reset_reg5", oa[5], 32'd0);
        check("reset_dirty", dirty_a, 32'd0);
        check("reset_ack", {31'd0, ack_a}, 32'd0);

        // Reset drops data and a concurrent write.
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        check("wr5_data", oa[5], 32'hDEADBEEF);
        check("wr5_ack", {31'd0, ack_a}, 32'd1);
        cyc(1'b1, 5'd5, 32'h11111111, 1'b0, 1'b1);
        check("rst_reg5", oa[5], 32'd0);
        check("rst_dirty", dirty_a, 32'd0);
        check("rst_ack", {31'd0, ack_a}, 32'd0);

        // Write then read through the mux.
        sel = 5'd2;
        cyc(1'b1, 5'd2, 32'h7FFFFFFF, 1'b0, 1'b0);
        check("mux_sel2", mux_out, 32'h7FFFFFFF);
        check("dirty_bit2", dirty_a, 32'h00000004);
        check("ack_pulse", {31'd0, ack_a}, 32'd1);
        cyc(1'b0, 5'd2, 32'd0, 1'b0, 1'b0);
        check("ack_drop", {31'd0, ack_a}, 32'd0);
        sel = 5'd4;
        #1;
        check("mux_sel4", mux_out, 32'd0);

        // Entry 0: hardwired vs ordinary.
        cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("z_reg0", oa[0], 32'd0);
        check("z_dirty0", {31'd0, dirty_a[0]}, 32'd0);
        check("z_ack", {31'd0, ack_a}, 32'd0);
        check("nz_reg0", ob[0], 32'hFFFFFFFF);
        check("nz_dirty0", {31'd0, dirty_b[0]}, 32'd1);
        check("nz_ack", {31'd0, ack_b}, 32'd1);

        // Back-to-back sweep of addresses 1..31.
        for (int n = 1; n < 32; n++) begin
            cyc(1'b1, 5'(n), 32'h100 + 32'(n), 1'b0, 1'b0);
            check($sformatf("sweep_ack%0d", n), {31'd0, ack_a}, 32'd1);
        end
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("sweep_dirty_a", dirty_a, 32'hFFFFFFFE);
        check("sweep_dirty_b", dirty_b, 32'hFFFFFFFF);
        for (int n = 1; n < 32; n++) begin
            check($sformatf("sweep_reg%0d", n), oa[n], 32'h100 + 32'(n));
        end

        // Hold: idle cycles with random address/data must not change anything.
        for (int n = 0; n < 4; n++) cyc(1'b0, 5'($urandom), $urandom, 1'b0, 1'b0);
        check("hold_reg31", oa[31], 32'h11F);

        // Dirty clear collision.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check("clr_dirty", dirty_a, 32'd0);
        cyc(1'b1, 5'd2, 32'h22, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 32'h33, 1'b0, 1'b0);
        check("dirty_c", dirty_a, 32'h0000000C);
        cyc(1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
        check("clr_collide", dirty_a, 32'h00000080);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check("clr_alone", dirty_a, 32'd0);
        check("clr_keep7", oa[7], 32'h77);
        check("clr_keep3", oa[3], 32'h33);

        // Repeated writes to one address.
        cyc(1'b1, 5'd9, 32'h55555555, 1'b0, 1'b0);
        cyc(1'b1, 5'd9, 32'hAAAA0000, 1'b0, 1'b0);
        check("rep_reg9", oa[9], 32'hAAAA0000);
        check("rep_ack", {31'd0, ack_a}, 32'd1);

        // Same-cycle read returns the old value.
        Write     = 1'b1;
        WriteAddr = 5'd9;
        WriteData = 32'h12345678;
        #1;
        check("same_cycle_old", oa[9], 32'hAAAA0000);
        @(negedge Clk);
        check("same_cycle_new", oa[9], 32'h12345678);

        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
